// File: rtl/x_iddr_capture.sv
// Input DDR capture register: samples D on both edges of C and presents the
// rising/falling samples as Q1/Q2 in one of three pairing modes.
`timescale 1ps/1ps

module x_iddr_capture #(
  parameter string DDR_CLK_EDGE = "OPPOSITE_EDGE",
  parameter logic  INIT_Q1      = 1'b0,
  parameter logic  INIT_Q2      = 1'b0
) (
  input  logic C,
  input  logic R,
  input  logic S,
  input  logic CE,
  input  logic D,
  output logic Q1,
  output logic Q2
);

  typedef enum logic [1:0] {
    MODE_OPP  = 2'd0,
    MODE_SAME = 2'd1,
    MODE_PIPE = 2'd2
  } mode_e;

  localparam mode_e MODE = (DDR_CLK_EDGE == "SAME_EDGE")           ? MODE_SAME :
                           (DDR_CLK_EDGE == "SAME_EDGE_PIPELINED") ? MODE_PIPE :
                                                                     MODE_OPP;

  if (!(DDR_CLK_EDGE == "OPPOSITE_EDGE" || DDR_CLK_EDGE == "SAME_EDGE" ||
        DDR_CLK_EDGE == "SAME_EDGE_PIPELINED")) begin : g_bad_edge
    $fatal(1, "%m: illegal DDR_CLK_EDGE value %s", DDR_CLK_EDGE);
  end
  if (INIT_Q1 !== 1'b0 && INIT_Q1 !== 1'b1) begin : g_bad_init_q1
    $fatal(1, "%m: INIT_Q1 must be 0 or 1");
  end
  if (INIT_Q2 !== 1'b0 && INIT_Q2 !== 1'b1) begin : g_bad_init_q2
    $fatal(1, "%m: INIT_Q2 must be 0 or 1");
  end

  logic pos_q;
  logic neg_q;
  logic q1_q;
  logic q2_q;
  logic set_eff;

  // Set is qualified by ~R so that dropping R while S is still high raises
  // set_eff and re-triggers the set branch.
  assign set_eff = S & ~R;

  always_ff @(posedge C or posedge R or posedge set_eff) begin
    if (R) begin
      pos_q <= INIT_Q1;
      q1_q  <= INIT_Q1;
      q2_q  <= INIT_Q2;
    end else if (set_eff) begin
      pos_q <= 1'b1;
      q1_q  <= 1'b1;
      q2_q  <= 1'b1;
    end else if (CE) begin
      pos_q <= D;
      case (MODE)
        MODE_SAME: begin
          q1_q <= D;
          q2_q <= neg_q;
        end
        MODE_PIPE: begin
          q1_q <= pos_q;
          q2_q <= neg_q;
        end
        default: begin
          q1_q <= D;
        end
      endcase
    end
  end

  always_ff @(negedge C or posedge R or posedge set_eff) begin
    if (R) begin
      neg_q <= INIT_Q2;
    end else if (set_eff) begin
      neg_q <= 1'b1;
    end else if (CE) begin
      neg_q <= D;
    end
  end

  // In OPPOSITE_EDGE mode the falling-edge capture register is the Q2 output.
  assign Q1 = q1_q;
  assign Q2 = (MODE == MODE_OPP) ? neg_q : q2_q;

endmodule
